sad_search_ctrl: RTL

- Sequences a full-search block-matching pass of the RImgSize x RImgSize reference block over the SImgSize x SImgSize search image.
- Issues read addresses to the 4-port search memory and to the 2-port reference memory, accumulates absolute differences and tracks the minimum SAD.
- Sits between the top-level start/status logic and the search/reference image memories; the result is reported as a sad_t.

---
 rtl/sad_search_ctrl_if.sv | 45 ++++
 rtl/sad_search_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_search_ctrl_if.sv
// Controller-side bundle: start/status handshake, search and reference memory ports, result.
// Types live here so the controller, memories and bench share one definition.
interface sad_search_ctrl_if #(
    parameter int SImgSize = 31,
    parameter int RImgSize = 16
);
    localparam int SAW = $clog2(SImgSize * SImgSize);
    localparam int RAW = $clog2(RImgSize * RImgSize);

    typedef struct packed {
        logic                 write;
        logic [SAW-1:0]       waddr;
        logic [7:0]           wdata;
        logic [3:0][SAW-1:0]  raddr;
    } smem_req_t;

    typedef struct packed {
        logic [3:0][7:0] data;
    } smem_res_t;

    typedef struct packed {
        logic [16:0]    sad;
        logic [SAW-1:0] addr;
    } sad_t;

    logic                 start_i;
    logic                 busy_o;
    logic                 done_o;
    smem_req_t            smem_req_o;
    smem_res_t            smem_res_i;
    logic [1:0][RAW-1:0]  rmem_raddr_o;
    logic [1:0][7:0]      rmem_rdata_i;
    sad_t                 best_o;
    logic                 best_valid_o;

    modport master (
        input  start_i, smem_res_i, rmem_rdata_i,
        output busy_o, done_o, smem_req_o, rmem_raddr_o, best_o, best_valid_o
    );

    modport slave (
        output start_i, smem_res_i, rmem_rdata_i,
        input  busy_o, done_o, smem_req_o, rmem_raddr_o, best_o, best_valid_o
    );
endinterface

// File: rtl/sad_search_ctrl.sv
// Full-search SAD block matcher: one two-candidate beat per cycle, result MemLat+1 cycles after the last beat.
// No backpressure: both memories are fixed-latency, so issue never stalls once a run starts.
module sad_search_ctrl #(
    parameter int SImgSize = 31,
    parameter int RImgSize = 16,
    parameter int MemLat   = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    sad_search_ctrl_if.master bus
);
    localparam int NC  = SImgSize - RImgSize + 1;
    localparam int SAW = $clog2(SImgSize * SImgSize);
    localparam int RAW = $clog2(RImgSize * RImgSize);
    localparam int JW  = $clog2(RImgSize);
    localparam int CW  = $clog2(NC);
    localparam int LCW = 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e state_q, state_d;
    logic   start_acc, issue, busy, done;
    logic [LCW-1:0] lat_q;

    logic [JW-1:0]  j_q, j_d, r_q, r_d;
    logic [CW-1:0]  x_q, x_d, y_q, y_d;
    logic [SAW-1:0] row_base_q, row_base_d, cand_base_q, cand_base_d;
    logic [SAW-1:0] line_base_q, line_base_d;
    logic [RAW-1:0] ref_base_q, ref_base_d;
    logic           j_end, r_end, x_end, y_end, last_beat;

    logic [MemLat-1:0] tv_q, tf_q, tl_q;
    logic [SAW-1:0]    ta_q [MemLat];
    logic              ret_vld, ret_first, ret_last;
    logic [SAW-1:0]    ret_addr;

    logic [3:0][7:0]     s_dat;
    logic [1:0][7:0]     r_dat;
    logic [8:0]          d0, d1;
    logic [16:0]         acc0_q, acc1_q, sum0, sum1, pick_sum;
    logic                pick1;
    logic [16:0]         best_sad_q, best_sad_d;
    logic [SAW-1:0]      best_addr_q, best_addr_d;
    logic [16:0]         bo_sad_q;
    logic [SAW-1:0]      bo_addr_q;
    logic                best_valid_q;
    logic [3:0][SAW-1:0] raddr;
    logic [1:0][RAW-1:0] rref;
    logic [SAW-1:0]      a0;

    function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start_i) state_d = S_RUN;
            S_RUN:   if (last_beat) state_d = S_DRAIN;
            S_DRAIN: if (lat_q == LCW'(MemLat - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        start_acc = 1'b0;
        issue     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE:  start_acc = bus.start_i;
            S_RUN:   begin issue = 1'b1; busy = 1'b1; end
            S_DRAIN: busy = 1'b1;
            S_DONE:  begin busy = 1'b1; done = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                lat_q <= '0;
        else if (state_q == S_DRAIN) lat_q <= lat_q + LCW'(1);
        else                        lat_q <= '0;
    end

    assign j_end     = (j_q == JW'(RImgSize - 2));
    assign r_end     = (r_q == JW'(RImgSize - 1));
    assign x_end     = (x_q == CW'(NC - 2));
    assign y_end     = (y_q == CW'(NC - 1));
    assign last_beat = j_end & r_end & x_end & y_end;

    // Row/candidate bases advance by adds only; line_base tracks y*SImgSize.
    always_comb begin
        j_d = j_q;  r_d = r_q;  x_d = x_q;  y_d = y_q;
        row_base_d  = row_base_q;
        cand_base_d = cand_base_q;
        line_base_d = line_base_q;
        ref_base_d  = ref_base_q;
        if (start_acc) begin
            j_d = '0;  r_d = '0;  x_d = '0;  y_d = '0;
            row_base_d = '0;  cand_base_d = '0;  line_base_d = '0;  ref_base_d = '0;
        end else if (issue) begin
            if (!j_end) begin
                j_d = j_q + JW'(2);
            end else begin
                j_d = '0;
                if (!r_end) begin
                    r_d        = r_q + JW'(1);
                    row_base_d = row_base_q + SAW'(SImgSize);
                    ref_base_d = ref_base_q + RAW'(RImgSize);
                end else begin
                    r_d        = '0;
                    ref_base_d = '0;
                    if (!x_end) begin
                        x_d         = x_q + CW'(2);
                        cand_base_d = cand_base_q + SAW'(2);
                        row_base_d  = cand_base_q + SAW'(2);
                    end else begin
                        x_d         = '0;
                        y_d         = y_end ? '0 : y_q + CW'(1);
                        line_base_d = y_end ? '0 : line_base_q + SAW'(SImgSize);
                        cand_base_d = line_base_d;
                        row_base_d  = line_base_d;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            j_q <= '0;  r_q <= '0;  x_q <= '0;  y_q <= '0;
            row_base_q <= '0;  cand_base_q <= '0;  line_base_q <= '0;  ref_base_q <= '0;
        end else begin
            j_q <= j_d;  r_q <= r_d;  x_q <= x_d;  y_q <= y_d;
            row_base_q  <= row_base_d;
            cand_base_q <= cand_base_d;
            line_base_q <= line_base_d;
            ref_base_q  <= ref_base_d;
        end
    end

    assign a0       = row_base_q + SAW'(j_q);
    assign raddr[0] = issue ? a0 : '0;
    assign raddr[1] = issue ? a0 + SAW'(1) : '0;
    assign raddr[2] = issue ? a0 + SAW'(1) : '0;
    assign raddr[3] = issue ? a0 + SAW'(2) : '0;
    assign rref[0]  = issue ? ref_base_q + RAW'(j_q) : '0;
    assign rref[1]  = issue ? ref_base_q + RAW'(j_q) + RAW'(1) : '0;

    // Tags ride alongside the memory read so they line up with returning data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tv_q <= '0;
            tf_q <= '0;
            tl_q <= '0;
            for (int k = 0; k < MemLat; k++) ta_q[k] <= '0;
        end else begin
            for (int k = MemLat - 1; k > 0; k--) begin
                tv_q[k] <= tv_q[k-1];
                tf_q[k] <= tf_q[k-1];
                tl_q[k] <= tl_q[k-1];
                ta_q[k] <= ta_q[k-1];
            end
            tv_q[0] <= issue;
            tf_q[0] <= (j_q == '0) && (r_q == '0);
            tl_q[0] <= j_end && r_end;
            ta_q[0] <= cand_base_q;
        end
    end

    assign ret_vld   = tv_q[MemLat-1];
    assign ret_first = tf_q[MemLat-1];
    assign ret_last  = tl_q[MemLat-1];
    assign ret_addr  = ta_q[MemLat-1];

    assign s_dat = bus.smem_res_i.data;
    assign r_dat = bus.rmem_rdata_i;
    assign d0    = 9'(absdiff(s_dat[0], r_dat[0])) + 9'(absdiff(s_dat[1], r_dat[1]));
    assign d1    = 9'(absdiff(s_dat[2], r_dat[0])) + 9'(absdiff(s_dat[3], r_dat[1]));
    assign sum0  = ret_first ? 17'(d0) : acc0_q + 17'(d0);
    assign sum1  = ret_first ? 17'(d1) : acc1_q + 17'(d1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc0_q <= '0;
            acc1_q <= '0;
        end else if (ret_vld) begin
            acc0_q <= sum0;
            acc1_q <= sum1;
        end
    end

    // set0 wins in-pair ties; strict compare keeps the earlier pair on cross-pair ties.
    always_comb begin
        best_sad_d  = best_sad_q;
        best_addr_d = best_addr_q;
        pick1       = (sum1 < sum0);
        pick_sum    = pick1 ? sum1 : sum0;
        if (start_acc) begin
            best_sad_d  = 17'h1FFFF;
            best_addr_d = '0;
        end else if (ret_vld && ret_last && (pick_sum < best_sad_q)) begin
            best_sad_d  = pick_sum;
            best_addr_d = ret_addr + SAW'(pick1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            best_sad_q   <= 17'h1FFFF;
            best_addr_q  <= '0;
            bo_sad_q     <= '0;
            bo_addr_q    <= '0;
            best_valid_q <= 1'b0;
        end else begin
            best_sad_q  <= best_sad_d;
            best_addr_q <= best_addr_d;
            if (start_acc) begin
                bo_sad_q     <= '0;
                bo_addr_q    <= '0;
                best_valid_q <= 1'b0;
            end else if ((state_q == S_DRAIN) && (state_d == S_DONE)) begin
                bo_sad_q     <= best_sad_d;
                bo_addr_q    <= best_addr_d;
                best_valid_q <= 1'b1;
            end
        end
    end

    assign bus.busy_o       = busy;
    assign bus.done_o       = done;
    assign bus.best_valid_o = best_valid_q;
    assign bus.best_o       = {bo_sad_q, bo_addr_q};
    assign bus.smem_req_o   = {1'b0, {SAW{1'b0}}, 8'h00, raddr};
    assign bus.rmem_raddr_o = rref;
endmodule
